// File: rtl/pc_sequencer.sv
// Fetch-stage program-counter sequencer: four next-PC modes, stall,
// start-up gating, misaligned-target fault with recovery, advance counter.
module pc_sequencer #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [ADDR_WIDTH-1:0] FAULT_VECTOR = ADDR_WIDTH'('h100),
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  stall,
  input  logic [1:0]            pc_src,
  input  logic [ADDR_WIDTH-1:0] imm_op,
  input  logic [ADDR_WIDTH-1:0] rs1_val,
  input  logic                  fault_clr,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] pc_plus4,
  output logic                  fetch_valid,
  output logic                  fault,
  output logic [ADDR_WIDTH-1:0] fault_addr,
  output logic [CNT_WIDTH-1:0]  step_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    FAULT = 2'b10
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] FOUR = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] NOT1 = ~ADDR_WIDTH'(1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  fault_q, fault_d;
  logic [ADDR_WIDTH-1:0] fault_addr_q, fault_addr_d;
  logic [CNT_WIDTH-1:0]  step_q, step_d;
  logic                  fv_q, fv_d;
  logic [ADDR_WIDTH-1:0] target;

  always_comb begin
    target = pc_q + FOUR;
    unique case (pc_src)
      2'b00: target = pc_q + FOUR;
      2'b01: target = pc_q + imm_op;
      2'b10: target = (rs1_val + imm_op) & NOT1;
      2'b11: target = imm_op;
      default: target = pc_q + FOUR;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fault_d      = fault_q;
    fault_addr_d = fault_addr_q;
    step_d       = step_q;
    unique case (state_q)
      IDLE: begin
        if (en) state_d = RUN;
      end
      RUN: begin
        if (!stall) begin
          if (target[1:0] == 2'b00) begin
            pc_d   = target;
            step_d = step_q + CNT_WIDTH'(1);
          end else begin
            state_d      = FAULT;
            fault_d      = 1'b1;
            fault_addr_d = target;
          end
        end
      end
      FAULT: begin
        if (fault_clr) begin
          state_d = RUN;
          pc_d    = FAULT_VECTOR;
          fault_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    fv_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pc_q         <= RESET_VECTOR;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
      step_q       <= '0;
      fv_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
      step_q       <= step_d;
      fv_q         <= fv_d;
    end
  end

  assign pc          = pc_q;
  assign pc_plus4    = pc_q + FOUR;
  assign fetch_valid = fv_q;
  assign fault       = fault_q;
  assign fault_addr  = fault_addr_q;
  assign step_count  = step_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset, modes, stall, fault/recovery,
// address wrap and a narrow-counter instance for step_count wrap.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic        stall = 1'b0;
  logic [1:0]  pc_src = 2'b00;
  logic [31:0] imm_op = '0;
  logic [31:0] rs1_val = '0;
  logic        fault_clr = 1'b0;
  logic [31:0] pc, pc_plus4, fault_addr, step_count;
  logic        fetch_valid, fault;

  logic        s_en = 1'b0;
  logic [31:0] s_pc, s_pc_plus4, s_fault_addr;
  logic        s_fv, s_fault;
  logic [3:0]  s_step;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pc_sequencer u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .stall(stall),
    .pc_src(pc_src), .imm_op(imm_op), .rs1_val(rs1_val),
    .fault_clr(fault_clr), .pc(pc), .pc_plus4(pc_plus4),
    .fetch_valid(fetch_valid), .fault(fault),
    .fault_addr(fault_addr), .step_count(step_count)
  );

  pc_sequencer #(.CNT_WIDTH(4)) u_small (
    .clk(clk), .rst_n(rst_n), .en(s_en), .stall(1'b0),
    .pc_src(2'b00), .imm_op(32'h0), .rs1_val(32'h0),
    .fault_clr(1'b0), .pc(s_pc), .pc_plus4(s_pc_plus4),
    .fetch_valid(s_fv), .fault(s_fault),
    .fault_addr(s_fault_addr), .step_count(s_step)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    step();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_fv", fetch_valid, 1'b0);
    chk("rst_fault", fault, 1'b0);
    chk("rst_faddr", fault_addr, 32'h0);
    chk("rst_cnt", step_count, 32'h0);
    chk("rst_p4", pc_plus4, 32'h4);
    step();
    rst_n = 1'b1;
    repeat (3) step();
    chk("idle_pc", pc, 32'h0);
    chk("idle_fv", fetch_valid, 1'b0);

    en = 1'b1;
    step();
    en = 1'b0;
    chk("start_fv", fetch_valid, 1'b1);
    chk("start_pc", pc, 32'h0);
    chk("start_cnt", step_count, 32'h0);

    step(); chk("seq1", pc, 32'h4);
    step(); chk("seq2", pc, 32'h8);
    step(); chk("seq3", pc, 32'hC);
    chk("seq_cnt", step_count, 32'd3);
    chk("seq_p4", pc_plus4, 32'h10);

    stall = 1'b1; pc_src = 2'b11; imm_op = 32'h40;
    repeat (2) step();
    chk("stall_pc", pc, 32'hC);
    chk("stall_cnt", step_count, 32'd3);
    stall = 1'b0;

    pc_src = 2'b01; imm_op = 32'hFFFF_FFF8;
    step(); chk("rel_pc", pc, 32'h4);
    chk("rel_cnt", step_count, 32'd4);
    pc_src = 2'b10; rs1_val = 32'h201; imm_op = 32'h10;
    step(); chk("ind_pc", pc, 32'h210);
    chk("ind_cnt", step_count, 32'd5);
    pc_src = 2'b11; imm_op = 32'h400;
    step(); chk("abs_pc", pc, 32'h400);
    chk("abs_cnt", step_count, 32'd6);

    pc_src = 2'b01; imm_op = 32'h6;
    step();
    chk("mis_fault", fault, 1'b1);
    chk("mis_addr", fault_addr, 32'h406);
    chk("mis_pc", pc, 32'h400);
    chk("mis_fv", fetch_valid, 1'b0);
    chk("mis_cnt", step_count, 32'd6);

    pc_src = 2'b00; stall = 1'b1; en = 1'b1;
    repeat (2) step();
    chk("hold_fault", fault, 1'b1);
    chk("hold_pc", pc, 32'h400);
    chk("hold_fv", fetch_valid, 1'b0);
    stall = 1'b0; en = 1'b0;

    fault_clr = 1'b1; pc_src = 2'b11; imm_op = 32'h800;
    step();
    fault_clr = 1'b0;
    chk("clr_pc", pc, 32'h100);
    chk("clr_fault", fault, 1'b0);
    chk("clr_fv", fetch_valid, 1'b1);
    chk("clr_faddr", fault_addr, 32'h406);

    pc_src = 2'b10; rs1_val = 32'h3; imm_op = 32'h0;
    step();
    chk("jalr_fault", fault, 1'b1);
    chk("jalr_addr", fault_addr, 32'h2);
    chk("jalr_pc", pc, 32'h100);
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    chk("clr2_pc", pc, 32'h100);
    chk("clr2_cnt", step_count, 32'd6);

    pc_src = 2'b11; imm_op = 32'hFFFF_FFFC;
    step(); chk("top_pc", pc, 32'hFFFF_FFFC);
    chk("top_p4", pc_plus4, 32'h0);
    pc_src = 2'b00;
    step();
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_fault", fault, 1'b0);
    chk("wrap_cnt", step_count, 32'd8);

    pc_src = 2'b01; imm_op = 32'h2;
    step();
    chk("f3_fault", fault, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mr_pc", pc, 32'h0);
    chk("mr_fault", fault, 1'b0);
    chk("mr_faddr", fault_addr, 32'h0);
    chk("mr_cnt", step_count, 32'h0);
    chk("mr_fv", fetch_valid, 1'b0);
    step();
    rst_n = 1'b1;
    pc_src = 2'b00;
    step();
    chk("mr_idle_fv", fetch_valid, 1'b0);
    chk("mr_idle_pc", pc, 32'h0);
    en = 1'b1;
    step();
    en = 1'b0;
    chk("mr_run_fv", fetch_valid, 1'b1);

    s_en = 1'b1;
    step();
    s_en = 1'b0;
    chk("s_fv", s_fv, 1'b1);
    repeat (15) step();
    chk("s_cnt15", s_step, 4'd15);
    step();
    chk("s_cnt_wrap", s_step, 4'd0);
    chk("s_pc", s_pc, 32'h40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
